// File: rtl/float_to_int.sv
// float_to_int
//   Converts an IEEE-754 single-precision value to a signed 32-bit integer,
//   rounding toward zero. The float arrives as two 16-bit words (high word
//   first) and the integer leaves as two 16-bit words (high word first).
//   The block is a multi-cycle state machine that uses an iterative
//   one-bit-per-cycle shifter.
//
//   Handshake (both directions): a word moves on a rising edge where stb=1
//   and ack=1. The side that drives ack or stb drops it in the cycle after
//   the transfer. The output word is registered together with output_z_stb
//   and is held stable for as long as the downstream stalls.
//
// Ports
//   clk          : system clock, rising edge
//   rst          : synchronous, active-high reset
//   input_a      : float32 word in (high half, then low half)
//   input_a_stb  : upstream has a valid word on input_a
//   input_a_ack  : block is ready to take a word on input_a
//   output_z     : int32 word out (high half, then low half)
//   output_z_stb : output_z is valid
//   output_z_ack : downstream accepts output_z
module float_to_int (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   output logic [15:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);

   typedef enum logic [2:0] {
      get_a,
      get_a_lo,
      unpack,
      special_cases,
      convert,
      pack,
      put_z,
      put_z_lo
   } state_t;

   state_t             state, next_state;
   logic        [31:0] a;
   logic        [31:0] m;
   logic signed [9:0]  e;
   logic               s;
   logic        [31:0] z;

   logic               ack_d;
   logic               stb_d;
   logic        [15:0] z_word_d;

   wire a_xfer = input_a_ack  & input_a_stb;
   wire z_xfer = output_z_stb & output_z_ack;

   // Unbiased exponent classes used by the special-case check.
   wire e_inf_nan  = (e == 10'sd128);
   wire e_too_big  = (e >  10'sd30);
   wire e_too_small = (e <  10'sd0);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= get_a;
      else     state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         get_a:         if (a_xfer) next_state = get_a_lo;
         get_a_lo:      if (a_xfer) next_state = unpack;
         unpack:        next_state = special_cases;
         special_cases: begin
            if (e_inf_nan || e_too_big || e_too_small) next_state = put_z;
            else                                       next_state = convert;
         end
         // The last shift happens when e steps from 30 to 31, so the
         // transition to pack is taken in that same cycle.
         convert:       if (e == 10'sd30) next_state = pack;
         pack:          next_state = put_z;
         put_z:         if (z_xfer) next_state = put_z_lo;
         put_z_lo:      if (z_xfer) next_state = get_a;
         default:       next_state = get_a;
      endcase
   end

   // Output logic: next values of the registered handshake outputs.
   always_comb begin
      ack_d    = 1'b0;
      stb_d    = 1'b0;
      z_word_d = output_z;
      case (state)
         get_a, get_a_lo: ack_d = ~a_xfer;
         put_z: begin
            stb_d    = ~z_xfer;
            z_word_d = z[31:16];
         end
         put_z_lo: begin
            stb_d    = ~z_xfer;
            z_word_d = z[15:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         input_a_ack  <= 1'b0;
         output_z_stb <= 1'b0;
         output_z     <= 16'd0;
      end else begin
         input_a_ack  <= ack_d;
         output_z_stb <= stb_d;
         output_z     <= z_word_d;
      end
   end

   // Datapath registers, advanced according to the current state.
   always_ff @(posedge clk) begin
      if (rst) begin
         a <= 32'd0;
         m <= 32'd0;
         e <= 10'sd0;
         s <= 1'b0;
         z <= 32'd0;
      end else begin
         case (state)
            get_a:    if (a_xfer) a[31:16] <= input_a;
            get_a_lo: if (a_xfer) a[15:0]  <= input_a;
            unpack: begin
               m <= {1'b1, a[22:0], 8'd0};
               e <= $signed({2'b00, a[30:23]}) - 10'sd127;
               s <= a[31];
            end
            special_cases: begin
               // 0x80000000 doubles as the saturated value and the exact
               // encoding of -2^31.
               if (e_inf_nan || e_too_big) z <= 32'h8000_0000;
               else if (e_too_small)       z <= 32'd0;
            end
            convert: begin
               m <= m >> 1;
               e <= e + 10'sd1;
            end
            pack: z <= s ? -m : m;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_float_to_int.sv
module tb_float_to_int;

   logic        clk;
   logic        rst;
   logic [15:0] input_a;
   logic        input_a_stb;
   logic        input_a_ack;
   logic [15:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack;

   int checks;
   int failures;

   localparam int BUDGET = 100;

   float_to_int dut (
      .clk          (clk),
      .rst          (rst),
      .input_a      (input_a),
      .input_a_stb  (input_a_stb),
      .input_a_ack  (input_a_ack),
      .output_z     (output_z),
      .output_z_stb (output_z_stb),
      .output_z_ack (output_z_ack)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one word upstream; returns after the transfer edge (+1).
   task automatic send_word(input logic [15:0] w);
      int n;
      n = 0;
      input_a     = w;
      input_a_stb = 1'b1;
      while (!input_a_ack && n < BUDGET) begin
         step();
         n++;
      end
      if (n >= BUDGET) chk("send_timeout", 32'(n), 32'(BUDGET - 1));
      step();
      input_a_stb = 1'b0;
   endtask

   // Wait for output_z_stb with ack low; returns cycles waited.
   task automatic wait_stb(output int n);
      n = 0;
      while (!output_z_stb && n < BUDGET) begin
         step();
         n++;
      end
      if (n >= BUDGET) chk("recv_timeout", 32'(n), 32'(BUDGET - 1));
   endtask

   task automatic recv_word(output logic [15:0] w);
      int n;
      wait_stb(n);
      w            = output_z;
      output_z_ack = 1'b1;
      step();
      output_z_ack = 1'b0;
   endtask

   task automatic run_vec(input string tag, input logic [31:0] f, input logic [31:0] exp);
      logic [15:0] hi, lo;
      send_word(f[31:16]);
      send_word(f[15:0]);
      recv_word(hi);
      recv_word(lo);
      chk(tag, {hi, lo}, exp);
   endtask

   initial begin
      logic [15:0] hi, lo, held;
      int lat;
      checks       = 0;
      failures     = 0;
      rst          = 1'b1;
      input_a      = 16'd0;
      input_a_stb  = 1'b0;
      output_z_ack = 1'b0;
      step();
      step();
      chk("reset_ack", 32'(input_a_ack), 32'd0);
      chk("reset_stb", 32'(output_z_stb), 32'd0);
      chk("reset_z", 32'(output_z), 32'd0);
      rst = 1'b0;
      step();
      chk("ack_after_reset", 32'(input_a_ack), 32'd1);

      // Directed conversions
      run_vec("one",      32'h3F80_0000, 32'h0000_0001);
      run_vec("neg_2p5",  32'hC020_0000, 32'hFFFF_FFFE);
      run_vec("max_e30",  32'h4EFF_FFFF, 32'h7FFF_FF80);
      run_vec("neg_2p31", 32'hCF00_0000, 32'h8000_0000);
      run_vec("nan",      32'h7FC0_0000, 32'h8000_0000);
      run_vec("pos_inf",  32'h7F80_0000, 32'h8000_0000);
      run_vec("p075",     32'h3F40_0000, 32'h0000_0000);
      run_vec("neg_zero", 32'h8000_0000, 32'h0000_0000);
      run_vec("denorm",   32'h0000_0001, 32'h0000_0000);
      run_vec("big_sat",  32'h5000_0000, 32'h8000_0000);

      // Latency: 1.0 has e=0 -> 4+31 cycles; NaN takes the 3-cycle path.
      send_word(16'h3F80);
      send_word(16'h0000);
      wait_stb(lat);
      chk("lat_normal", 32'(lat), 32'd35);
      recv_word(hi);
      recv_word(lo);
      chk("lat_normal_val", {hi, lo}, 32'h0000_0001);
      send_word(16'h7FC0);
      send_word(16'h0000);
      wait_stb(lat);
      chk("lat_special", 32'(lat), 32'd3);
      recv_word(hi);
      recv_word(lo);
      chk("lat_special_val", {hi, lo}, 32'h8000_0000);

      // Backpressure: high word stalled for 7 cycles.
      send_word(16'h4040);
      send_word(16'h0000);
      wait_stb(lat);
      held = output_z;
      chk("bp_held_val", 32'(held), 32'h0000);
      for (int i = 0; i < 7; i++) begin
         step();
         chk("bp_stb", 32'(output_z_stb), 32'd1);
         chk("bp_z", 32'(output_z), 32'(held));
         chk("bp_ack", 32'(input_a_ack), 32'd0);
      end
      recv_word(hi);
      recv_word(lo);
      chk("bp_val", {hi, lo}, 32'h0000_0003);
      step();
      chk("bp_reenter_get_a", 32'(input_a_ack), 32'd1);

      // Gap of 5 idle cycles between input words of 123.0.
      send_word(16'h42F6);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("gap_ack", 32'(input_a_ack), 32'd1);
         chk("gap_stb", 32'(output_z_stb), 32'd0);
      end
      send_word(16'h0000);
      recv_word(hi);
      recv_word(lo);
      chk("gap_val", {hi, lo}, 32'h0000_007B);

      // Reset after the high word is accepted.
      send_word(16'h4040);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_ack", 32'(input_a_ack), 32'd0);
      chk("midrst_stb", 32'(output_z_stb), 32'd0);
      step();
      chk("midrst_stb2", 32'(output_z_stb), 32'd0);
      run_vec("after_rst", 32'h4040_0000, 32'h0000_0003);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
